// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 source-side framer.
// SHA3_PAD_KECCAK_EN: when defined, selects the original Keccak pad suffix 0x01
// instead of the SHA-3 domain suffix 0x06.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'd0,
    SHA256 = 2'd1,
    SHA384 = 2'd2,
    SHA512 = 2'd3
  } digest_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2
  } state_e;

`ifdef SHA3_PAD_KECCAK_EN
  localparam logic [7:0] PAD_SUFFIX = 8'h01;
`else
  localparam logic [7:0] PAD_SUFFIX = 8'h06;
`endif
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  // Sponge rate in 16-bit words for each digest size.
  function automatic logic [6:0] rate_words(input logic [1:0] sel);
    logic [6:0] r;
    case (sel)
      SHA224:  r = 7'd72;
      SHA256:  r = 7'd68;
      SHA384:  r = 7'd52;
      default: r = 7'd36;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha3_word_packer.sv
// Byte-to-word packer: tracks byte position, holds the low byte and owns the
// output word register with its valid/ready handshake and sideband flags.
module sha3_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pos_clr_i,
  input  logic [7:0]  byte_i,
  input  logic        load_i,
  input  logic [15:0] word_i,
  input  logic        tid_i,
  input  logic        last_i,
  input  logic        ready_i,
  output logic        byte_pos_o,
  output logic [7:0]  low_o,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        tid_o,
  output logic        last_o
);

  logic        pos_q, pos_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        tid_q, tid_d;
  logic        last_q, last_d;

  // Next-state for position, holding byte and output register; a load wins over a drain.
  always_comb begin
    pos_d   = pos_q;
    low_d   = low_q;
    data_d  = data_q;
    valid_d = valid_q;
    tid_d   = tid_q;
    last_d  = last_q;
    if (push_i && !pos_q) low_d = byte_i;
    if (pos_clr_i)        pos_d = 1'b0;
    else if (push_i)      pos_d = ~pos_q;
    if (load_i) begin
      data_d  = word_i;
      tid_d   = tid_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Packer state registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q   <= 1'b0;
      low_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tid_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      low_q   <= low_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tid_q   <= tid_d;
      last_q  <= last_d;
    end
  end

  assign byte_pos_o = pos_q;
  assign low_o      = low_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign tid_o      = tid_q;
  assign last_o     = last_q;

endmodule

// File: rtl/sha3_pad_framer.sv
// SHA-3 source framer: packs a byte stream into 16-bit words, applies
// multi-rate padding and marks block / message ends.
// SHA3_PAD_KECCAK_EN (see sha3_pkg) selects the Keccak pad suffix.
module sha3_pad_framer
  import sha3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [1:0]       USER,
  input  logic [7:0]       S_TDATA,
  input  logic             S_TVALID,
  output logic             S_TREADY,
  input  logic             S_TLAST,
  input  logic             S_TKEEP,
  output logic [WIDTH-1:0] TDATA_o,
  output logic             TVALID_o,
  input  logic             TREADY,
  output logic             TID_o,
  output logic             TLAST_o,
  output logic [1:0]       TUSER_o,
  output logic             BUSY_o
);

  state_e      state_q, state_d;
  logic [1:0]  tuser_q, tuser_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic        sfx_q, sfx_d;
  logic        rdy_q;

  logic        out_valid, out_hs, in_hs;
  logic        byte_pos;
  logic [7:0]  low_byte;
  logic [6:0]  rate_msg, rate_ld, cnt_inc, slot;
  logic        slot_end;
  logic        load, push, pos_clr, ld_last;
  logic [15:0] ld_word;

  assign out_hs   = out_valid && TREADY;
  assign S_TREADY = rdy_q && (state_q == IDLE || state_q == FILL) && (!out_valid || TREADY);
  assign in_hs    = S_TVALID && S_TREADY;

  // Slot of a word loaded this cycle: the register is either empty (slot = word_cnt)
  // or draining now (slot = word_cnt + 1). A first beat in IDLE always starts at
  // slot 0 and is sized by the incoming USER, not the previous message's rate.
  assign rate_msg = rate_words(tuser_q);
  assign rate_ld  = (state_q == IDLE) ? rate_words(USER) : rate_msg;
  assign cnt_inc  = (word_cnt_q == rate_msg - 7'd1) ? '0 : word_cnt_q + 7'd1;
  assign slot     = (state_q == IDLE) ? '0 : (out_hs ? cnt_inc : word_cnt_q);
  assign slot_end = (slot == rate_ld - 7'd1);

  // Next state, byte routing and pad word formation.
  always_comb begin
    state_d    = state_q;
    tuser_d    = tuser_q;
    sfx_d      = sfx_q;
    word_cnt_d = out_hs ? cnt_inc : word_cnt_q;
    load       = 1'b0;
    push       = 1'b0;
    pos_clr    = 1'b0;
    ld_word    = '0;
    ld_last    = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (in_hs) begin
          if (state_q == IDLE) begin
            tuser_d = USER;
            state_d = FILL;
            sfx_d   = 1'b0;
          end
          push = S_TKEEP;
          if (!S_TLAST) begin
            if (byte_pos) begin
              load    = 1'b1;
              ld_word = {S_TDATA, low_byte};
            end
          end else begin
            pos_clr = 1'b1;
            if (S_TKEEP && byte_pos) begin
              load    = 1'b1;
              ld_word = {S_TDATA, low_byte};
              state_d = PAD;
            end else if (!S_TKEEP && !byte_pos) begin
              state_d = PAD;
            end else begin
              // Last data byte sits in the low half: suffix shares its word.
              load    = 1'b1;
              sfx_d   = 1'b1;
              ld_word = {(slot_end ? PAD_FINAL : 8'h00) | PAD_SUFFIX,
                         S_TKEEP ? S_TDATA : low_byte};
              ld_last = slot_end;
              state_d = slot_end ? IDLE : PAD;
            end
          end
        end
      end
      PAD: begin
        if (!out_valid || TREADY) begin
          load    = 1'b1;
          sfx_d   = 1'b1;
          ld_word = {slot_end ? PAD_FINAL : 8'h00, sfx_q ? 8'h00 : PAD_SUFFIX};
          ld_last = slot_end;
          if (slot_end) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; rdy_q holds S_TREADY low until the first edge after reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      tuser_q    <= '0;
      word_cnt_q <= '0;
      sfx_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tuser_q    <= tuser_d;
      word_cnt_q <= word_cnt_d;
      sfx_q      <= sfx_d;
      rdy_q      <= 1'b1;
    end
  end

  sha3_word_packer u_packer (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .push_i     (push),
    .pos_clr_i  (pos_clr),
    .byte_i     (S_TDATA),
    .load_i     (load),
    .word_i     (ld_word),
    .tid_i      (slot_end),
    .last_i     (ld_last),
    .ready_i    (TREADY),
    .byte_pos_o (byte_pos),
    .low_o      (low_byte),
    .data_o     (TDATA_o),
    .valid_o    (out_valid),
    .tid_o      (TID_o),
    .last_o     (TLAST_o)
  );

  assign TVALID_o = out_valid;
  assign TUSER_o  = tuser_q;
  assign BUSY_o   = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_sha3_pad_framer.sv
// Self-checking bench for sha3_pad_framer: byte-level pad model plus scoreboard.
module tb_sha3_pad_framer;

`ifdef SHA3_PAD_KECCAK_EN
  localparam logic [7:0] P = 8'h01;
`else
  localparam logic [7:0] P = 8'h06;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        tid;
    logic        last;
    logic [1:0]  tuser;
  } exp_t;

  logic        ACLK, ARESET;
  logic [1:0]  USER;
  logic [7:0]  S_TDATA;
  logic        S_TVALID, S_TREADY, S_TLAST, S_TKEEP;
  logic [15:0] TDATA_o;
  logic        TVALID_o, TREADY, TID_o, TLAST_o, BUSY_o;
  logic [1:0]  TUSER_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  mbuf[$];
  logic [15:0] exp_w[$];
  exp_t        exp_q[$];
  bit          discard = 0;
  bit          stall_en = 0;

  sha3_pad_framer #(.WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .USER(USER),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .S_TLAST(S_TLAST), .S_TKEEP(S_TKEEP),
    .TDATA_o(TDATA_o), .TVALID_o(TVALID_o), .TREADY(TREADY),
    .TID_o(TID_o), .TLAST_o(TLAST_o), .TUSER_o(TUSER_o), .BUSY_o(BUSY_o)
  );

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    TREADY = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      TREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: message || P || 0* with 0x80 ORed into the final rate byte.
  task automatic model_push(input logic [1:0] usr);
    int unsigned r, n;
    logic [7:0]  pb[$];
    exp_t        e;
    r = (usr == 2'd0) ? 72 : (usr == 2'd1) ? 68 : (usr == 2'd2) ? 52 : 36;
    pb = mbuf;
    pb.push_back(P);
    while (pb.size() % (2 * r) != 0) pb.push_back(8'h00);
    pb[pb.size() - 1] = pb[pb.size() - 1] | 8'h80;
    n = pb.size() / 2;
    exp_w.delete();
    for (int unsigned i = 0; i < n; i++) begin
      e.data  = {pb[2*i+1], pb[2*i]};
      e.tid   = (i % r) == r - 1;
      e.last  = (i == n - 1);
      e.tuser = usr;
      exp_q.push_back(e);
      exp_w.push_back(e.data);
    end
  endtask

  task automatic drive(input logic [1:0] usr, input bit ktail, input bit gaps,
                       input int unsigned abort_after);
    int unsigned nb, waited;
    bit hs;
    nb = (mbuf.size() == 0) ? 1 : mbuf.size() + (ktail ? 1 : 0);
    for (int unsigned i = 0; i < nb; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        S_TVALID = 0; @(posedge ACLK); #1;
      end
      S_TVALID = 1;
      if (i < mbuf.size()) begin S_TDATA = mbuf[i]; S_TKEEP = 1; end
      else begin S_TDATA = 8'($urandom); S_TKEEP = 0; end
      S_TLAST = (i == nb - 1);
      USER = (i == 0) ? usr : 2'($urandom);
      hs = 0; waited = 0;
      while (!hs && waited < 2000) begin
        @(negedge ACLK); hs = S_TREADY;
        @(posedge ACLK); #1;
        waited++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL beat_timeout: beat %0d not accepted, required acceptance within 2000 cycles", i);
        S_TVALID = 0;
        return;
      end
      if (abort_after != 0 && i + 1 == abort_after) break;
    end
    S_TVALID = 0; S_TLAST = 0; S_TKEEP = 0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || BUSY_o) && n < 3000) begin
      @(posedge ACLK); #1; n++;
    end
    check("drain_pending_busy", {exp_q.size(), BUSY_o}, 33'd0);
  endtask

  task automatic load_bytes(input int unsigned len);
    mbuf.delete();
    for (int unsigned i = 0; i < len; i++) mbuf.push_back(8'($urandom));
  endtask

  // Output compare: word scoreboard, stall stability and ready back-pressure.
  logic        prev_stall = 0;
  logic [19:0] prev_out;
  always @(negedge ACLK) begin
    exp_t e;
    if (ARESET) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_stable", {TVALID_o, TDATA_o, TID_o, TLAST_o, TUSER_o}, {1'b1, prev_out});
      if (TVALID_o && !TREADY)
        check("sready_in_stall", S_TREADY, 1'b0);
      if (TVALID_o)
        check("busy_with_word", BUSY_o, 1'b1);
      if (TVALID_o && TREADY && !discard) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {TDATA_o, TID_o, TLAST_o, TUSER_o}, 20'hxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("word", {TDATA_o, TID_o, TLAST_o, TUSER_o}, e);
        end
      end
      prev_stall = TVALID_o && !TREADY;
      prev_out   = {TDATA_o, TID_o, TLAST_o, TUSER_o};
    end
  end

  logic [15:0] w;

  initial begin
    ARESET = 1; USER = 0; S_TDATA = 0; S_TVALID = 0; S_TLAST = 0; S_TKEEP = 0;
    repeat (2) @(posedge ACLK);
    #1;
    check("reset_outputs", {S_TREADY, TVALID_o, TDATA_o, TID_o, TLAST_o, TUSER_o, BUSY_o}, 32'd0);
    @(negedge ACLK); ARESET = 0;
    @(posedge ACLK); #1;

    // "abc", SHA-256
    mbuf = '{8'h61, 8'h62, 8'h63};
    model_push(2'd1);
    check("abc_nwords", exp_w.size(), 68);
    w = exp_w[0];  check("abc_w0", w, 16'h6261);
    w = exp_w[1];  check("abc_w1", w, {P, 8'h63});
    w = exp_w[66]; check("abc_w66", w, 16'h0000);
    w = exp_w[67]; check("abc_w67", w, 16'h8000);
    drive(2'd1, 0, 0, 0);
    drain();

    // empty message, SHA-512
    mbuf.delete();
    model_push(2'd3);
    check("empty_nwords", exp_w.size(), 36);
    w = exp_w[0];  check("empty_w0", w, {8'h00, P});
    w = exp_w[35]; check("empty_w35", w, 16'h8000);
    drive(2'd3, 0, 0, 0);
    drain();

    // 135 bytes: suffix and final bit share the last byte
    load_bytes(135);
    model_push(2'd1);
    check("b135_nwords", exp_w.size(), 68);
    w = exp_w[67]; check("b135_hi", w[15:8], P | 8'h80);
    drive(2'd1, 0, 0, 0);
    drain();

    // 136 bytes: full padding block follows
    load_bytes(136);
    model_push(2'd1);
    check("b136_nwords", exp_w.size(), 136);
    w = exp_w[68];  check("b136_w68", w, {8'h00, P});
    w = exp_w[135]; check("b136_w135", w, 16'h8000);
    drive(2'd1, 0, 0, 0);
    drain();

    // "abc" under random back-pressure
    stall_en = 1;
    mbuf = '{8'h61, 8'h62, 8'h63};
    model_push(2'd1);
    drive(2'd1, 0, 1, 0);
    drain();
    stall_en = 0;

    // reset in the middle of a SHA-384 message
    load_bytes(20);
    discard = 1;
    drive(2'd2, 0, 0, 10);
    check("busy_mid_msg", BUSY_o, 1'b1);
    #2 ARESET = 1;
    #1;
    check("async_reset_outputs", {S_TREADY, TVALID_o, TDATA_o, TID_o, TLAST_o, TUSER_o, BUSY_o}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESET = 0; discard = 0;
    @(posedge ACLK); #1;

    // "abc", SHA-224 after reset
    mbuf = '{8'h61, 8'h62, 8'h63};
    model_push(2'd0);
    check("abc224_nwords", exp_w.size(), 72);
    w = exp_w[1]; check("abc224_w1", w, {P, 8'h63});
    drive(2'd0, 0, 0, 0);
    drain();

    // random back-to-back messages, random stalls, keep=0 tails, USER churn
    stall_en = 1;
    for (int unsigned m = 0; m < 25; m++) begin
      logic [1:0] u;
      u = 2'($urandom_range(0, 3));
      load_bytes($urandom_range(0, 200));
      model_push(u);
      drive(u, $urandom_range(0, 1) == 1, 1, 0);
    end
    drain();
    stall_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

endmodule

// File: doc/sha3_pad_framer.md
# sha3_pad_framer

Source-side framer for the SHA-3 core. It accepts a byte stream of arbitrary-length messages and packs the bytes into WIDTH-bit words. It applies SHA-3 multi-rate padding and emits rate-sized blocks on the core's word-stream input, marking each block boundary and the final block of each message. It replaces bench-side padding and block counting: the digest width is selected once per message, and the block emits exactly rate/WIDTH words per block.

## Interface
- WIDTH, 16, output word width; only 16 supported (rate sizes are multiples of 16 bits)
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- USER  in  2  digest select: 0=224, 1=256, 2=384, 3=512; latched on first accepted beat of a message
- S_TDATA  in  8  message byte
- S_TVALID  in  1  byte valid
- S_TREADY  out  1  framer accepts byte this cycle
- S_TLAST  in  1  beat is last of message
- S_TKEEP  in  1  beat carries a byte; 0 legal only with S_TLAST=1 (empty tail / empty message)
- TDATA_o  out  WIDTH  packed word, first byte in [7:0], second in [15:8]
- TVALID_o  out  1  word valid
- TREADY  in  1  downstream accepts word
- TID_o  out  1  word is last word of a block
- TLAST_o  out  1  word is last word of final block of message
- TUSER_o  out  2  latched digest select for the current message
- BUSY_o  out  1  message in progress (first beat accepted, final word not yet accepted)

## Operation
- Rate in words, from USER: 0→72, 1→68, 2→52, 3→36.
- State machine:
  - IDLE: wait for a first beat; latch USER into TUSER_o; go to FILL.
  - FILL: pack bytes; after the S_TLAST beat, go to PAD or to IDLE.
  - PAD: emit padding words up to the end of the final block.
- Packing:
  - byte_pos toggles 0/1.
  - Position 0: store the byte in the low holding register.
  - Position 1: form the word {byte, low} and load it into the output register.
- word_cnt: 0..rate-1, increments on each output handshake and wraps to 0. TID_o=1 when word_cnt==rate-1.
- Padding (suffix P=0x06), applied at the first byte position after the last data byte:
  - Last byte at position 0: word = {P, byte}. If this word is the last of its block, the high byte is P|0x80 (0x86).
  - Last byte at position 1, or S_TKEEP=0 tail: the next word is 0x0006, or 0x8006 if it is the last word of a block.
  - A data word that completes a block leaves the message unpadded; a full padding block follows (0x0006, zeros, 0x8000).
  - Remaining words of the final block are 0x0000. The last word has 0x80 in its high byte.
- TLAST_o=TID_o on the final block only. After the TLAST_o handshake: go to IDLE, BUSY_o=0, word_cnt=0, byte_pos=0.
- USER changes mid-message are ignored.

## Timing
- Reset values: S_TREADY=0, TVALID_o=0, TDATA_o=0, TID_o=0, TLAST_o=0, TUSER_o=0, BUSY_o=0. The state machine resets to IDLE, and counters and holding registers reset to 0.
- S_TREADY = (IDLE or FILL) and (!TVALID_o or TREADY). This is combinational from TREADY.
- The output register loads one cycle after the completing byte handshake: TVALID_o rises the cycle after.
- Peak throughput: 1 byte/cycle in, 1 word per 2 cycles out.
- PAD emits 1 word/cycle while TREADY=1.
- TDATA_o, TID_o, TLAST_o, TUSER_o stay stable while TVALID_o && !TREADY.
- A simultaneous output handshake and new load in the same cycle is legal: the register reloads and TVALID_o stays high.
- No new message is accepted until the previous TLAST_o word is accepted. S_TREADY=0 in PAD.
- ARESET mid-message: the partial message is discarded, all outputs return to reset values asynchronously, and no trailing words are emitted.

## Configuration
- SHA3_PAD_KECCAK_EN selects the padding suffix.
  - Defined: suffix P=0x01 (original Keccak pad10*1). First pad byte 0x01; combined first/last byte 0x81.
  - Undefined: SHA-3 suffix P=0x06; combined byte 0x86.
- Nothing else changes.

## Structure
- Package sha3_pkg holds:
  - the digest-select enum (SHA224..SHA512)
  - the rate_words function
  - constants PAD_SUFFIX (macro-dependent) and PAD_FINAL=0x80
  - the state enum (IDLE, FILL, PAD)
- One sub-module, sha3_word_packer: byte_pos, low holding register, and output register with valid/ready.
- The top holds the state machine, word_cnt and pad insertion.

## Test plan
- "abc" (0x61,0x62,0x63), USER=1 → 68 words: 0x6261, 0x0663, 65×0x0000, 0x8000; TID_o=TLAST_o=1 only on word 68.
- Empty message (S_TKEEP=0, S_TLAST=1), USER=3 → 36 words: 0x0006, 34×0x0000, 0x8000.
- 135 bytes, USER=1 → single block, word 68 = 0x86xx.
- 136 bytes, USER=1 → two blocks:
  - block 1 ends with TID_o=1, TLAST_o=0;
  - block 2 = 0x0006, 66×0x0000, 0x8000 with TLAST_o=1.
- Random TREADY stalls on "abc" → TDATA_o stable during every stall, S_TREADY=0 while stalled with a full word pending, identical word sequence.
- ARESET asserted after 10 bytes of a USER=2 message → all outputs 0 immediately. A following "abc" with USER=0 yields 72 words, TUSER_o=0, and no residue.
- With SHA3_PAD_KECCAK_EN: "abc", USER=1 → second word 0x0163.
